// File: rtl/ram_boot_loader.sv
// Boot loader: takes a length-prefixed, checksummed byte stream and packs the payload into
// little-endian 32-bit RAM writes. The core stays in reset until the image is verified.
module ram_boot_loader #(
  parameter int MEM_WIDTH = 65536,
  parameter int BASE_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx_valid_i,
  input  logic [7:0]                   rx_data_i,
  output logic                         rx_ready_o,
  output logic                         en_o,
  output logic [3:0]                   we_o,
  output logic [$clog2(MEM_WIDTH)-1:0] addr_o,
  output logic [31:0]                  data_o,
  output logic                         core_reset_n_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [$clog2(MEM_WIDTH)-1:0] words_written_o
);
  localparam int              AW      = $clog2(MEM_WIDTH);
  localparam logic [31:0]     MAX_LEN = 32'(MEM_WIDTH - BASE_ADDR);
  localparam logic [AW-1:0]   BASE    = AW'(BASE_ADDR);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_hdr_cnt;
  logic [31:0]   r_len;
  logic [31:0]   r_byte_cnt;
  logic [31:0]   r_stage;
  logic [7:0]    r_sum;
  logic [AW-1:0] r_wr_addr;

  logic          w_accept;
  logic          w_last;
  logic          w_write;
  logic [1:0]    w_lane;
  logic [3:0]    w_we;
  logic [31:0]   w_len;
  logic [31:0]   w_stage;

  assign w_accept = rx_valid_i & rx_ready_o;
  assign w_lane   = r_byte_cnt[1:0];
  assign w_len    = {rx_data_i, r_len[23:0]};
  assign w_last   = (r_byte_cnt + 32'd1) == r_len;
  // The staging word is cleared after every write, so unfilled lanes of a flush are zero.
  assign w_stage  = r_stage | ({24'd0, rx_data_i} << {w_lane, 3'b000});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_LEN;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_we        = 4'b0000;
    unique case (r_state)
      S_LEN: begin
        if (w_accept && r_hdr_cnt == 2'd3) begin
          if (w_len > MAX_LEN)    w_state_nxt = S_ERR;
          else if (w_len == 32'd0) w_state_nxt = S_CHK;
          else                     w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && (w_lane == 2'd3 || w_last)) begin
          w_write = 1'b1;
          unique case (w_lane)
            2'd0: w_we = 4'b0001;
            2'd1: w_we = 4'b0011;
            2'd2: w_we = 4'b0111;
            2'd3: w_we = 4'b1111;
          endcase
          if (w_last) w_state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (w_accept) w_state_nxt = (rx_data_i == r_sum) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready_o      <= 1'b0;
      en_o            <= 1'b0;
      we_o            <= 4'b0000;
      addr_o          <= BASE;
      data_o          <= 32'd0;
      core_reset_n_o  <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      words_written_o <= '0;
      r_hdr_cnt       <= 2'd0;
      r_len           <= 32'd0;
      r_byte_cnt      <= 32'd0;
      r_stage         <= 32'd0;
      r_sum           <= 8'd0;
      r_wr_addr       <= BASE;
    end else begin
      // Ready is registered from the next state so it drops on the same edge the stream ends.
      rx_ready_o <= (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA) || (w_state_nxt == S_CHK);
      en_o       <= w_write;
      we_o       <= w_we;

      if (w_write) begin
        addr_o          <= r_wr_addr;
        data_o          <= w_stage;
        r_wr_addr       <= r_wr_addr + AW'(4);
        words_written_o <= words_written_o + AW'(1);
        r_stage         <= 32'd0;
      end else if (w_accept && r_state == S_DATA) begin
        r_stage <= w_stage;
      end

      if (w_accept && r_state == S_LEN) begin
        r_len[{r_hdr_cnt, 3'b000} +: 8] <= rx_data_i;
        r_hdr_cnt                       <= r_hdr_cnt + 2'd1;
      end

      if (w_accept && r_state == S_DATA) begin
        r_byte_cnt <= r_byte_cnt + 32'd1;
        r_sum      <= r_sum + rx_data_i;
      end

      if (w_state_nxt == S_DONE) begin
        done_o         <= 1'b1;
        core_reset_n_o <= 1'b1;
      end
      if (w_state_nxt == S_ERR) error_o <= 1'b1;
    end
  end
endmodule
